// File: rtl/branch_unit_bht_if.sv
// Resolve-request and result handshake bundle between execute and the
// branch unit. The unit itself uses the slave modport.
interface branch_unit_bht_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                  in_valid;
    logic                  in_ready;
    logic [1:0]            in_type;
    logic [2:0]            in_func3;
    logic [DATA_WIDTH-1:0] in_rs1;
    logic [DATA_WIDTH-1:0] in_rs2;
    logic [DATA_WIDTH-1:0] in_imm;
    logic [ADDR_WIDTH-1:0] in_pc;
    logic                  in_pred_taken;

    logic                  out_valid;
    logic                  out_ready;
    logic                  out_taken;
    logic [ADDR_WIDTH-1:0] out_redirect_pc;
    logic                  out_mispredict;
    logic                  out_illegal;

    modport master (
        output in_valid, in_type, in_func3, in_rs1, in_rs2, in_imm, in_pc, in_pred_taken,
        input  in_ready,
        input  out_valid, out_taken, out_redirect_pc, out_mispredict, out_illegal,
        output out_ready
    );

    modport slave (
        input  in_valid, in_type, in_func3, in_rs1, in_rs2, in_imm, in_pc, in_pred_taken,
        output in_ready,
        output out_valid, out_taken, out_redirect_pc, out_mispredict, out_illegal,
        input  out_ready
    );
endinterface

// File: rtl/branch_unit_bht.sv
// Branch resolution unit: B-type/JAL/JALR compare and target, a single result
// register with valid/ready, a bimodal saturating-counter BHT and statistics.
module branch_unit_bht #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int BHT_DEPTH  = 16,
    parameter int CTR_WIDTH  = 2,
    parameter int STAT_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] lk_pc,
    output logic                  lk_taken,
    branch_unit_bht_if.slave      bus,
    output logic [STAT_WIDTH-1:0] stat_branches,
    output logic [STAT_WIDTH-1:0] stat_mispredicts
);
    localparam int IDX_W = $clog2(BHT_DEPTH);
    localparam int EXT_W = (DATA_WIDTH > ADDR_WIDTH) ? DATA_WIDTH : ADDR_WIDTH;
    localparam logic [CTR_WIDTH-1:0] CTR_MAX  = '1;
    localparam logic [CTR_WIDTH-1:0] CTR_INIT = CTR_WIDTH'((1 << (CTR_WIDTH - 1)) - 1);

    typedef enum logic [1:0] {
        T_NONE = 2'b00,
        T_JAL  = 2'b01,
        T_BR   = 2'b10,
        T_JALR = 2'b11
    } br_type_e;

    logic [CTR_WIDTH-1:0]  r_bht [BHT_DEPTH];
    logic                  r_out_valid;
    logic                  r_out_taken;
    logic [ADDR_WIDTH-1:0] r_out_redirect_pc;
    logic                  r_out_mispredict;
    logic                  r_out_illegal;
    logic [STAT_WIDTH-1:0] r_stat_branches;
    logic [STAT_WIDTH-1:0] r_stat_mispredicts;

    br_type_e              w_type;
    logic                  w_in_ready;
    logic                  w_in_fire;
    logic                  w_out_fire;
    logic [IDX_W-1:0]      w_lk_idx;
    logic [IDX_W-1:0]      w_up_idx;
    logic                  w_eq;
    logic                  w_lt_s;
    logic                  w_lt_u;
    logic                  w_cond;
    logic                  w_cond_illegal;
    logic                  w_taken;
    logic                  w_illegal;
    logic                  w_mispredict;
    logic signed [EXT_W-1:0] w_imm_ext;
    logic signed [EXT_W-1:0] w_rs1_ext;
    logic [ADDR_WIDTH-1:0] w_pc_rel;
    logic [ADDR_WIDTH-1:0] w_jalr_sum;
    logic [ADDR_WIDTH-1:0] w_seq_pc;
    logic [ADDR_WIDTH-1:0] w_target;
    logic [ADDR_WIDTH-1:0] w_redirect;
    logic [CTR_WIDTH-1:0]  w_ctr_cur;
    logic                  w_unused_ok;

    assign w_type     = br_type_e'(bus.in_type);
    assign w_in_ready = !r_out_valid || bus.out_ready;
    assign w_in_fire  = bus.in_valid && w_in_ready;
    assign w_out_fire = r_out_valid && bus.out_ready;

    // Fetch lookup and training share the same word-aligned index slice.
    assign w_lk_idx  = lk_pc[IDX_W+1:2];
    assign w_up_idx  = bus.in_pc[IDX_W+1:2];
    assign lk_taken  = r_bht[w_lk_idx][CTR_WIDTH-1];
    assign w_ctr_cur = r_bht[w_up_idx];

    assign w_eq   = (bus.in_rs1 == bus.in_rs2);
    assign w_lt_s = ($signed(bus.in_rs1) < $signed(bus.in_rs2));
    assign w_lt_u = (bus.in_rs1 < bus.in_rs2);

    always_comb begin
        w_cond         = 1'b0;
        w_cond_illegal = 1'b0;
        case (bus.in_func3)
            3'b000:  w_cond = w_eq;
            3'b001:  w_cond = !w_eq;
            3'b100:  w_cond = w_lt_s;
            3'b101:  w_cond = !w_lt_s;
            3'b110:  w_cond = w_lt_u;
            3'b111:  w_cond = !w_lt_u;
            default: w_cond_illegal = 1'b1;
        endcase
    end

    always_comb begin
        w_taken   = 1'b0;
        w_illegal = 1'b0;
        case (w_type)
            T_NONE: w_taken = 1'b0;
            T_JAL,
            T_JALR: w_taken = 1'b1;
            T_BR: begin
                w_taken   = w_cond;
                w_illegal = w_cond_illegal;
            end
            default: w_taken = 1'b0;
        endcase
    end

    // Offsets are sign-extended to the wider of the two widths, then every
    // address sum is truncated so it wraps modulo 2^ADDR_WIDTH.
    assign w_imm_ext  = EXT_W'($signed(bus.in_imm));
    assign w_rs1_ext  = EXT_W'($signed(bus.in_rs1));
    assign w_pc_rel   = bus.in_pc + w_imm_ext[ADDR_WIDTH-1:0];
    assign w_jalr_sum = w_rs1_ext[ADDR_WIDTH-1:0] + w_imm_ext[ADDR_WIDTH-1:0];
    assign w_seq_pc   = bus.in_pc + ADDR_WIDTH'(4);
    assign w_target   = (w_type == T_JALR) ? {w_jalr_sum[ADDR_WIDTH-1:1], 1'b0} : w_pc_rel;
    assign w_redirect = w_taken ? w_target : w_seq_pc;
    assign w_mispredict = w_taken ^ bus.in_pred_taken;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid       <= 1'b0;
            r_out_taken       <= 1'b0;
            r_out_redirect_pc <= '0;
            r_out_mispredict  <= 1'b0;
            r_out_illegal     <= 1'b0;
        end else if (w_in_fire) begin
            r_out_valid       <= 1'b1;
            r_out_taken       <= w_taken;
            r_out_redirect_pc <= w_redirect;
            r_out_mispredict  <= w_mispredict;
            r_out_illegal     <= w_illegal;
        end else if (w_out_fire) begin
            r_out_valid       <= 1'b0;
        end
    end

    // Illegal B-type encodings still train, as not-taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < BHT_DEPTH; i++) begin
                r_bht[i] <= CTR_INIT;
            end
        end else if (w_in_fire && (w_type == T_BR)) begin
            if (w_taken) begin
                if (w_ctr_cur != CTR_MAX) begin
                    r_bht[w_up_idx] <= w_ctr_cur + CTR_WIDTH'(1);
                end
            end else if (w_ctr_cur != '0) begin
                r_bht[w_up_idx] <= w_ctr_cur - CTR_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stat_branches    <= '0;
            r_stat_mispredicts <= '0;
        end else if (w_in_fire) begin
            if (w_type != T_NONE) begin
                r_stat_branches <= r_stat_branches + STAT_WIDTH'(1);
            end
            if (w_mispredict) begin
                r_stat_mispredicts <= r_stat_mispredicts + STAT_WIDTH'(1);
            end
        end
    end

    assign bus.in_ready        = w_in_ready;
    assign bus.out_valid       = r_out_valid;
    assign bus.out_taken       = r_out_taken;
    assign bus.out_redirect_pc = r_out_redirect_pc;
    assign bus.out_mispredict  = r_out_mispredict;
    assign bus.out_illegal     = r_out_illegal;
    assign stat_branches       = r_stat_branches;
    assign stat_mispredicts    = r_stat_mispredicts;

    // Low PC bits, bit 0 of the JALR sum and extension bits are not needed.
    assign w_unused_ok = ^{lk_pc, bus.in_pc, w_imm_ext, w_rs1_ext, w_jalr_sum};
endmodule

// File: tb/tb_branch_unit_bht.sv
// Self-checking bench for branch_unit_bht: directed vector table, randomized
// traffic against a behavioural model, and hand-written handshake/reset sequences.
module tb_branch_unit_bht;
    localparam int DW    = 32;
    localparam int AW    = 32;
    localparam int DEPTH = 16;
    localparam int CW    = 2;
    localparam int SW    = 32;
    localparam longint unsigned M32 = 64'h1_0000_0000;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] lk_pc = '0;
    logic          lk_taken;
    logic [SW-1:0] stat_b;
    logic [SW-1:0] stat_m;

    always #5 clk = ~clk;

    branch_unit_bht_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bif ();

    branch_unit_bht #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BHT_DEPTH(DEPTH), .CTR_WIDTH(CW), .STAT_WIDTH(SW)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .lk_pc            (lk_pc),
        .lk_taken         (lk_taken),
        .bus              (bif),
        .stat_branches    (stat_b),
        .stat_mispredicts (stat_m)
    );

    typedef struct {
        logic [1:0]  typ;
        logic [2:0]  f3;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] imm;
        logic [31:0] pc;
        logic        pred;
    } req_t;

    typedef struct {
        logic        taken;
        logic        ill;
        logic        mis;
        logic [31:0] red;
    } res_t;

    typedef struct {
        req_t r;
        res_t e;
    } vec_t;

    int              n_checks = 0;
    int              n_fail   = 0;
    int              bht_m [DEPTH];
    longint unsigned mb, mm;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic res_t ref_eval(input req_t r);
        res_t            o;
        int              sa, sb;
        longint unsigned ua, ub, pcv, immv, tgt;
        sa = r.rs1; sb = r.rs2;
        ua = r.rs1; ub = r.rs2;
        pcv = r.pc; immv = r.imm;
        o.ill = 1'b0;
        o.taken = 1'b0;
        if (r.typ == 2'd1 || r.typ == 2'd3) o.taken = 1'b1;
        else if (r.typ == 2'd2) begin
            case (r.f3)
                3'd0: o.taken = (ua == ub);
                3'd1: o.taken = (ua != ub);
                3'd4: o.taken = (sa < sb);
                3'd5: o.taken = (sa >= sb);
                3'd6: o.taken = (ua < ub);
                3'd7: o.taken = (ua >= ub);
                default: o.ill = 1'b1;
            endcase
        end
        if (r.typ == 2'd3) tgt = ((ua + immv) % M32) & ~64'd1;
        else               tgt = (pcv + immv) % M32;
        o.red = o.taken ? 32'(tgt) : 32'((pcv + 4) % M32);
        o.mis = o.taken ^ r.pred;
        return o;
    endfunction

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc / 4) % DEPTH);
    endfunction

    function automatic logic msb_of(input int i);
        return ((bht_m[i] >> (CW - 1)) & 1) != 0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) bht_m[i] = (1 << (CW - 1)) - 1;
        mb = 0;
        mm = 0;
    endtask

    task automatic model_fire(input req_t r);
        res_t e;
        int   i;
        e = ref_eval(r);
        if (r.typ != 2'd0) mb = (mb + 1) % M32;
        if (e.mis) mm = (mm + 1) % M32;
        if (r.typ == 2'd2) begin
            i = idx_of(r.pc);
            if (e.taken) bht_m[i] = (bht_m[i] + 1 > (1 << CW) - 1) ? (1 << CW) - 1 : bht_m[i] + 1;
            else         bht_m[i] = (bht_m[i] - 1 < 0) ? 0 : bht_m[i] - 1;
        end
    endtask

    task automatic drive_req(input req_t r);
        bif.in_type       = r.typ;
        bif.in_func3      = r.f3;
        bif.in_rs1        = r.rs1;
        bif.in_rs2        = r.rs2;
        bif.in_imm        = r.imm;
        bif.in_pc         = r.pc;
        bif.in_pred_taken = r.pred;
    endtask

    function automatic req_t mkreq(input logic [1:0] typ, input logic [2:0] f3, input logic [31:0] rs1,
                                   input logic [31:0] rs2, input logic [31:0] imm, input logic [31:0] pc,
                                   input logic pred);
        req_t r;
        r.typ = typ; r.f3 = f3; r.rs1 = rs1; r.rs2 = rs2; r.imm = imm; r.pc = pc; r.pred = pred;
        return r;
    endfunction

    function automatic vec_t mkv(input req_t r, input logic t, input logic [31:0] red,
                                 input logic mis, input logic ill);
        vec_t v;
        v.r = r; v.e.taken = t; v.e.red = red; v.e.mis = mis; v.e.ill = ill;
        return v;
    endfunction

    // Called at posedge+1; fires one request with out_ready high, returns at the
    // next posedge+1 with the result presented. lk_pre is lk_taken sampled just
    // before the accepting edge.
    task automatic send(input req_t r, output logic lk_pre);
        drive_req(r);
        bif.in_valid  = 1'b1;
        bif.out_ready = 1'b1;
        #1;
        lk_pre = lk_taken;
        chk("send_in_ready", 64'(bif.in_ready), 64'd1);
        @(posedge clk);
        model_fire(r);
        #1;
        bif.in_valid = 1'b0;
    endtask

    task automatic chk_res(input string tag, input res_t e);
        chk({tag, "_valid"},    64'(bif.out_valid),       64'd1);
        chk({tag, "_taken"},    64'(bif.out_taken),       64'(e.taken));
        chk({tag, "_redirect"}, 64'(bif.out_redirect_pc), 64'(e.red));
        chk({tag, "_mispred"},  64'(bif.out_mispredict),  64'(e.mis));
        chk({tag, "_illegal"},  64'(bif.out_illegal),     64'(e.ill));
    endtask

    task automatic chk_stats(input string tag);
        chk({tag, "_stat_branches"},    64'(stat_b), mb);
        chk({tag, "_stat_mispredicts"}, 64'(stat_m), mm);
    endtask

    task automatic apply_reset();
        #2;
        rst = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs [12];
        req_t rr, t_tk, t_nt, r1, r2;
        res_t mres;
        logic mv, iv, ordy, pre;

        vecs[0]  = mkv(mkreq(2'd2, 3'd0, 32'd5,        32'd5, 32'h20,       32'h100,      1'b0), 1, 32'h120,  1, 0);
        vecs[1]  = mkv(mkreq(2'd2, 3'd4, 32'hFFFFFFFF, 32'd1, 32'h10,       32'h200,      1'b1), 1, 32'h210,  0, 0);
        vecs[2]  = mkv(mkreq(2'd2, 3'd6, 32'hFFFFFFFF, 32'd1, 32'h10,       32'h204,      1'b1), 0, 32'h208,  1, 0);
        vecs[3]  = mkv(mkreq(2'd2, 3'd2, 32'd9,        32'd9, 32'h40,       32'h300,      1'b0), 0, 32'h304,  0, 1);
        vecs[4]  = mkv(mkreq(2'd3, 3'd0, 32'h1001,     32'd0, 32'd4,        32'h500,      1'b1), 1, 32'h1004, 0, 0);
        vecs[5]  = mkv(mkreq(2'd1, 3'd0, 32'd0,        32'd0, 32'd8,        32'hFFFFFFFC, 1'b1), 1, 32'h4,    0, 0);
        vecs[6]  = mkv(mkreq(2'd0, 3'd0, 32'd0,        32'd0, 32'h80,       32'h600,      1'b1), 0, 32'h604,  1, 0);
        vecs[7]  = mkv(mkreq(2'd2, 3'd1, 32'd3,        32'd4, 32'hFFFFFFF8, 32'h700,      1'b0), 1, 32'h6F8,  1, 0);
        vecs[8]  = mkv(mkreq(2'd2, 3'd5, 32'h80000000, 32'd0, 32'h100,      32'h800,      1'b0), 0, 32'h804,  0, 0);
        vecs[9]  = mkv(mkreq(2'd2, 3'd7, 32'h80000000, 32'd0, 32'h100,      32'h900,      1'b1), 1, 32'hA00,  0, 0);
        vecs[10] = mkv(mkreq(2'd0, 3'd0, 32'd0,        32'd0, 32'd0,        32'hFFFFFFFC, 1'b0), 0, 32'h0,    0, 0);
        vecs[11] = mkv(mkreq(2'd2, 3'd3, 32'd1,        32'd1, 32'h8,        32'h10,       1'b1), 0, 32'h14,   1, 1);

        bif.in_valid  = 1'b0;
        bif.out_ready = 1'b1;
        drive_req(mkreq(2'd0, 3'd0, 0, 0, 0, 0, 1'b0));
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        chk("reset_out_valid", 64'(bif.out_valid), 64'd0);
        chk("reset_in_ready",  64'(bif.in_ready),  64'd1);
        chk("reset_redirect",  64'(bif.out_redirect_pc), 64'd0);
        chk_stats("reset");

        for (int k = 0; k < 12; k++) begin
            send(vecs[k].r, pre);
            chk_res($sformatf("vec%0d", k), vecs[k].e);
            chk_stats($sformatf("vec%0d", k));
            lk_pc = vecs[k].r.pc;
            #1;
            chk($sformatf("vec%0d_lk", k), 64'(lk_taken), 64'(msb_of(idx_of(lk_pc))));
            @(posedge clk);
            #1;
        end

        // Randomized traffic with random backpressure.
        mv = 1'b0;
        mres = ref_eval(vecs[0].r);
        for (int c = 0; c < 400; c++) begin
            chk("rnd_out_valid", 64'(bif.out_valid), 64'(mv));
            if (mv) chk_res("rnd", mres);
            chk_stats("rnd");
            rr.typ  = 2'($urandom_range(0, 3));
            rr.f3   = 3'($urandom_range(0, 7));
            rr.rs1  = ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 7)) - 32'd3;
            rr.rs2  = ($urandom_range(0, 3) == 0) ? rr.rs1 : 32'($urandom_range(0, 7)) - 32'd3;
            rr.imm  = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 255)) - 32'd128;
            rr.pc   = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 31)) << 2;
            rr.pred = 1'($urandom_range(0, 1));
            iv   = ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 3) != 0);
            drive_req(rr);
            bif.in_valid  = iv;
            bif.out_ready = ordy;
            lk_pc = ($urandom_range(0, 1) != 0) ? rr.pc : 32'($urandom_range(0, 31)) << 2;
            #1;
            chk("rnd_in_ready", 64'(bif.in_ready), 64'(!mv || ordy));
            chk("rnd_lk", 64'(lk_taken), 64'(msb_of(idx_of(lk_pc))));
            @(posedge clk);
            if (iv && (!mv || ordy)) begin
                mres = ref_eval(rr);
                mv = 1'b1;
                model_fire(rr);
            end else if (mv && ordy) begin
                mv = 1'b0;
            end
            #1;
        end
        bif.in_valid  = 1'b0;
        bif.out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("rnd_drain_valid", 64'(bif.out_valid), 64'd0);

        // Counter saturation and read-before-write on the lookup port.
        apply_reset();
        t_tk = mkreq(2'd2, 3'd0, 32'd7, 32'd7, 32'h10, 32'h40, 1'b0);
        t_nt = mkreq(2'd2, 3'd1, 32'd7, 32'd7, 32'h10, 32'h40, 1'b0);
        lk_pc = 32'h40;
        for (int k = 0; k < 5; k++) begin
            send(t_tk, pre);
            chk_res($sformatf("sat_tk%0d", k), ref_eval(t_tk));
        end
        chk("sat_after5_lk", 64'(lk_taken), 64'd1);
        send(t_nt, pre);
        chk("sat_after_nt1_lk", 64'(lk_taken), 64'd1);
        send(t_nt, pre);
        chk("rbw_old_value", 64'(pre), 64'd1);
        chk("rbw_after_nt2_lk", 64'(lk_taken), 64'd0);
        chk_stats("sat");

        // Backpressure: result held while a second request waits.
        @(posedge clk);
        #1;
        r1 = mkreq(2'd1, 3'd0, 32'd0, 32'd0, 32'h80, 32'h1000, 1'b0);
        r2 = mkreq(2'd2, 3'd0, 32'd1, 32'd2, 32'h40, 32'h2000, 1'b1);
        bif.out_ready = 1'b0;
        drive_req(r1);
        bif.in_valid = 1'b1;
        #1;
        chk("bp_first_in_ready", 64'(bif.in_ready), 64'd1);
        @(posedge clk);
        model_fire(r1);
        #1;
        drive_req(r2);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("bp_hold%0d_in_ready", k), 64'(bif.in_ready), 64'd0);
            chk($sformatf("bp_hold%0d_redirect", k), 64'(bif.out_redirect_pc), 64'h1080);
            chk_res($sformatf("bp_hold%0d", k), ref_eval(r1));
            @(posedge clk);
            #1;
        end
        bif.out_ready = 1'b1;
        #1;
        chk("bp_release_in_ready", 64'(bif.in_ready), 64'd1);
        @(posedge clk);
        model_fire(r2);
        #1;
        bif.in_valid = 1'b0;
        chk("bp_second_redirect", 64'(bif.out_redirect_pc), 64'h2004);
        chk_res("bp_second", ref_eval(r2));
        @(posedge clk);
        #1;
        chk("bp_drained_valid", 64'(bif.out_valid), 64'd0);
        chk_stats("bp");

        // Asynchronous reset while a result is held.
        bif.out_ready = 1'b0;
        drive_req(vecs[0].r);
        bif.in_valid = 1'b1;
        @(posedge clk);
        model_fire(vecs[0].r);
        #1;
        bif.in_valid = 1'b0;
        chk("arst_pre_valid", 64'(bif.out_valid), 64'd1);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        chk("arst_out_valid", 64'(bif.out_valid), 64'd0);
        chk("arst_out_taken", 64'(bif.out_taken), 64'd0);
        chk("arst_redirect",  64'(bif.out_redirect_pc), 64'd0);
        chk("arst_mispred",   64'(bif.out_mispredict), 64'd0);
        chk("arst_in_ready",  64'(bif.in_ready), 64'd1);
        chk_stats("arst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        bif.out_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            lk_pc = 32'(i * 4);
            #1;
            chk($sformatf("arst_bht%0d_lk", i), 64'(lk_taken), 64'd0);
        end
        for (int i = 0; i < DEPTH; i++) begin
            t_tk = mkreq(2'd2, 3'd0, 32'd1, 32'd1, 32'h4, 32'h400 + 32'(i * 4), 1'b1);
            lk_pc = t_tk.pc;
            send(t_tk, pre);
            chk($sformatf("arst_bht%0d_one_taken", i), 64'(lk_taken), 64'(msb_of(i)));
        end
        chk_stats("final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/branch_unit_bht.md
Name: branch_unit_bht

Overview:
Pipelined branch resolution unit with a parametrised bimodal branch history table (BHT). It evaluates RV32 B-type compares, JAL and JALR, computes the target and redirect PC, and flags mispredictions against the fetch-stage prediction. It trains 2-bit-style saturating counters and keeps branch and mispredict statistics. It sits between decode/execute (valid/ready input) and the PC-select/redirect logic (valid/ready output); fetch uses the separate lookup port.

Parameters:
DATA_WIDTH, 32, operand width of rs1/rs2/imm
ADDR_WIDTH, 32, PC/target width
BHT_DEPTH, 16, number of BHT entries; power of two, >=2
CTR_WIDTH, 2, saturating counter width; >=1
STAT_WIDTH, 32, width of statistics counters

Ports:
clk  in  1  clock, all state updates on posedge
rst  in  1  asynchronous, active-high reset
lk_pc  in  ADDR_WIDTH  fetch lookup PC
lk_taken  out  1  combinational prediction: MSB of BHT[lk_pc index]
in_valid  in  1  resolve request valid
in_ready  out  1  unit can accept a request
in_type  in  2  00 none, 01 JAL, 10 B-type, 11 JALR
in_func3  in  3  B-type condition
in_rs1  in  DATA_WIDTH  operand 1
in_rs2  in  DATA_WIDTH  operand 2
in_imm  in  DATA_WIDTH  sign-extended offset
in_pc  in  ADDR_WIDTH  instruction PC
in_pred_taken  in  1  prediction made at fetch
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
out_taken  out  1  resolved taken
out_redirect_pc  out  ADDR_WIDTH  next PC: taken ? target : pc+4
out_mispredict  out  1  out_taken != registered pred_taken
out_illegal  out  1  B-type with func3 010/011
stat_branches  out  STAT_WIDTH  accepted requests with in_type != 00
stat_mispredicts  out  STAT_WIDTH  accepted requests with mispredict

Behaviour:
- Index = pc[log2(BHT_DEPTH)+1 : 2], used for both lookup and update.
- Handshake: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready; in_ready = !out_valid | out_ready (single-entry skid-free pipeline register).
- Latency: result registered, out_valid high the cycle after in_fire. A new request may be accepted in the same cycle as out_fire (full throughput).
- out_valid: set on in_fire; cleared on out_fire without in_fire. While out_valid & !out_ready, all out_* hold stable.
- Condition (B-type): 000 eq, 001 ne, 100 signed lt, 101 signed ge, 110 unsigned lt, 111 unsigned ge; 010/011 -> taken=0, illegal=1.
- JAL and JALR are always taken; type 00 is never taken.
- Targets: B/JAL = pc + imm; JALR = (rs1 + imm) with bit0 cleared. Truncate to ADDR_WIDTH; wrap modulo 2^ADDR_WIDTH, including pc+4 at top of the address space.
- Mispredict = taken XOR in_pred_taken for all types; type 00 with pred_taken=1 is a mispredict and redirects to pc+4.
- BHT update on the in_fire edge, B-type only (illegal func3 included, trained not-taken). Taken: saturating increment to 2^CTR_WIDTH-1. Not taken: saturating decrement to 0.
- Same-cycle lookup and update to the same index: lk_taken returns the pre-update value (read-before-write).
- Statistics: updated on in_fire; wrap at 2^STAT_WIDTH. stat_mispredicts increments only with mispredict.
- Reset (async, any time, including mid-transfer): out_valid=0, all out_* data=0, stats=0, every BHT counter=2^(CTR_WIDTH-1)-1 (weakly not-taken; 01 for CTR_WIDTH=2). An in-flight result is dropped; in_ready=1 after reset.

Test Plan:
- Reset, then B-type 000 with rs1=rs2=5, pc=0x100, imm=0x20, pred=0 -> next cycle out_taken=1, redirect=0x120, mispredict=1; BHT[0] goes 01->10; stat_branches=1, stat_mispredicts=1.
- Func3 100 vs 110 with rs1=0xFFFFFFFF, rs2=1 -> signed taken=1, unsigned taken=0; func3 010 -> illegal=1, taken=0, redirect=pc+4.
- JALR rs1=0x1001, imm=4, pred=1 -> redirect=0x1004, mispredict=0, BHT unchanged; JAL pc=0xFFFFFFFC, imm=8 -> redirect=0x4 (wrap).
- Four consecutive taken B-type at pc=0x40 -> counter saturates at 11, lk_taken(0x40)=1. A fifth taken keeps 11. Same-cycle lookup during the update returns the old MSB.
- Hold out_ready=0 for 3 cycles with a second request pending -> in_ready=0, outputs stable. Then raise out_ready -> both results delivered back-to-back with no bubble.
- Assert rst while out_valid=1 -> out_valid=0 immediately (async), stats=0, all BHT entries=01.
